// File: rtl/regfile_pkg.sv
// Shared definitions for the 4x32 register file and its sequencing masters.
package regfile_pkg;

    localparam int DW   = 32;
    localparam int AW   = 2;
    localparam int NREG = 1 << AW;
    localparam int ACCW = DW + AW;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WB      = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_accum_ctrl_if.sv
// Register file access bus: one read port (registered read data) and one write port.
interface regfile_accum_ctrl_if;
    import regfile_pkg::*;

    logic [AW-1:0] raddr;
    logic          ren;
    logic [DW-1:0] rdata;
    logic [AW-1:0] waddr;
    logic          wen;
    logic [DW-1:0] wdata;

    modport master (
        output raddr, ren, waddr, wen, wdata,
        input  rdata
    );

    modport slave (
        input  raddr, ren, waddr, wen, wdata,
        output rdata
    );

endinterface

// File: rtl/regfile_accum_ctrl_accum_sat.sv
// Writeback formatter: maps the widened accumulator onto one register word.
// Optional macro REGFILE_ACCUM_SAT_EN selects saturation instead of wrap-around.
module accum_sat
    import regfile_pkg::*;
(
    input  logic [ACCW-1:0] acc_i,
    output logic [DW-1:0]   wdata_o
);

    // Truncate, or clamp to all-ones when any carry bit above the word is set.
    always_comb begin
`ifdef REGFILE_ACCUM_SAT_EN
        if (|acc_i[ACCW-1:DW]) begin
            wdata_o = '1;
        end else begin
            wdata_o = acc_i[DW-1:0];
        end
`else
        wdata_o = acc_i[DW-1:0];
`endif
    end

endmodule

// File: rtl/regfile_accum_ctrl.sv
// Sequencing master: sums a masked subset of the register file and writes the
// low word back to a destination register. Fixed 9-cycle Start->Done latency.
// Optional macro REGFILE_ACCUM_SAT_EN (see accum_sat) saturates the writeback.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start; busy low
// ST_ISSUE   | read request for register idx (ren only if mask bit set)
// ST_CAPTURE | add rdata (or zero) into acc; advance idx or go to writeback
// ST_WB      | wen/done high for one cycle, result/ovf valid
module regfile_accum_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NREG-1:0]   mask,
    input  logic [AW-1:0]     dst,
    output logic              busy,
    output logic              done,
    output logic [ACCW-1:0]   result,
    output logic              ovf,
    regfile_accum_ctrl_if.master rf
);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [NREG-1:0] mask_q, mask_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [ACCW-1:0] result_q, result_d;
    logic            ovf_q, ovf_d;
    logic            ren_q, ren_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic [AW-1:0]   idx_inc;
    logic [DW-1:0]   add_val;
    logic [ACCW-1:0] acc_sum;
    logic [DW-1:0]   wdata_fmt;

    // The final sum is formatted combinationally so the write word is
    // registered on the same edge that enters writeback.
    accum_sat u_accum_sat (
        .acc_i   (acc_sum),
        .wdata_o (wdata_fmt)
    );

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        mask_d   = mask_q;
        dst_d    = dst_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        ren_d    = 1'b0;
        raddr_d  = raddr_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        idx_inc  = idx_q + 1'b1;
        add_val  = mask_q[idx_q] ? rf.rdata : '0;
        acc_sum  = acc_q + {{AW{1'b0}}, add_val};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = mask;
                    dst_d   = dst;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                    ren_d   = mask[0];
                    if (mask[0]) begin
                        raddr_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                acc_d = acc_sum;
                if (idx_q == AW'(NREG - 1)) begin
                    state_d  = ST_WB;
                    result_d = acc_sum;
                    ovf_d    = |acc_sum[ACCW-1:DW];
                    wen_d    = 1'b1;
                    waddr_d  = dst_q;
                    wdata_d  = wdata_fmt;
                    done_d   = 1'b1;
                end else begin
                    idx_d   = idx_inc;
                    state_d = ST_ISSUE;
                    ren_d   = mask_q[idx_inc];
                    if (mask_q[idx_inc]) begin
                        raddr_d = idx_inc;
                    end
                end
            end
            ST_WB: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            mask_q   <= '0;
            dst_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            ren_q    <= 1'b0;
            raddr_q  <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            mask_q   <= mask_d;
            dst_q    <= dst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            ren_q    <= ren_d;
            raddr_q  <= raddr_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign ovf      = ovf_q;
    assign rf.ren   = ren_q;
    assign rf.raddr = raddr_q;
    assign rf.wen   = wen_q;
    assign rf.waddr = waddr_q;
    assign rf.wdata = wdata_q;

endmodule

// File: tb/tb_regfile_accum_ctrl.sv
// Directed bench for regfile_accum_ctrl with a behavioural 4x32 register file.
module tb_regfile_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mask = '0;
    logic [1:0]  dst = '0;
    logic        busy, done, ovf;
    logic [33:0] result;

    regfile_accum_ctrl_if rf_if();

    regfile_accum_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mask   (mask),
        .dst    (dst),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .rf     (rf_if)
    );

    always #5 clk = ~clk;

    // Register file model: write port muxed between bench preload and DUT,
    // read data registered one cycle after ren.
    logic [31:0] mem [4];
    logic        pre_en = 1'b0;
    logic [1:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] rdata_r = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (rf_if.wen) mem[rf_if.waddr] <= rf_if.wdata;
        if (rf_if.ren) rdata_r <= mem[rf_if.raddr];
    end
    assign rf_if.rdata = rdata_r;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations recorded by run_op.
    int          done_cyc;
    int          done_cnt;
    int          wen_cnt;
    logic [15:0] ren_seen;
    logic [15:0] busy_seen;
    logic [1:0]  raddr_log [16];
    logic [31:0] wdata_at;
    logic [1:0]  waddr_at;
    logic [33:0] result_at;
    logic        ovf_at;
    logic [74:0] rst_snap;

    task automatic preload(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        logic [31:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pre_en = 1'b1; pre_addr = 2'(i); pre_data = v[i];
        end
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Start an operation and observe cycles 1..14 after the accepting edge.
    // xs: cycle to pulse a second start; rc: cycle to assert reset (0 = none).
    task automatic run_op(input logic [3:0] m, input logic [1:0] d,
                          input int xs, input int rc);
        done_cyc = 0; done_cnt = 0; wen_cnt = 0;
        ren_seen = '0; busy_seen = '0;
        wdata_at = '0; waddr_at = '0; result_at = '0; ovf_at = 1'b0;
        rst_snap = '1;
        @(negedge clk);
        start = 1'b1; mask = m; dst = d;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == xs) begin
                start = 1'b1; mask = 4'b0001; dst = 2'd1;
            end else begin
                start = 1'b0;
            end
            if (k == rc) begin
                rst_n = 1'b0;
                #1;
                rst_snap = {busy, done, ovf, rf_if.ren, rf_if.wen, rf_if.raddr,
                            rf_if.waddr, rf_if.wdata, result};
            end else begin
                rst_n = 1'b1;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
                result_at = result;
                ovf_at    = ovf;
            end
            if (rf_if.wen) begin
                wen_cnt++;
                wdata_at = rf_if.wdata;
                waddr_at = rf_if.waddr;
            end
            ren_seen[k]  = rf_if.ren;
            busy_seen[k] = busy;
            raddr_log[k] = rf_if.raddr;
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [74:0] snap;
        rst_n = 1'b0;
        #12;
        snap = {busy, done, ovf, rf_if.ren, rf_if.wen, rf_if.raddr,
                rf_if.waddr, rf_if.wdata, result};
        n_tests++;
        if (snap !== 75'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", snap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_sum_all;
        preload(32'd15, 32'd103, 32'd34, 32'd123);
        run_op(4'b1111, 2'd0, 0, 0);
        n_tests++;
        if (done_cyc !== 9 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL all_done_cycle: got cyc=%0d cnt=%0d want 9 1", done_cyc, done_cnt);
        end
        n_tests++;
        if (result_at !== 34'd275 || ovf_at !== 1'b0) begin
            n_fail++;
            $display("FAIL all_result: got %0d ovf=%b want 275 0", result_at, ovf_at);
        end
        n_tests++;
        if (mem[0] !== 32'd275 || wen_cnt !== 1 || waddr_at !== 2'd0) begin
            n_fail++;
            $display("FAIL all_writeback: r0=%0d wen_cnt=%0d waddr=%0d want 275 1 0",
                     mem[0], wen_cnt, waddr_at);
        end
        n_tests++;
        if (ren_seen !== 16'h00AA) begin
            n_fail++;
            $display("FAIL all_ren_pattern: got %h want 00aa", ren_seen);
        end
        n_tests++;
        if (busy_seen !== 16'h03FE) begin
            n_fail++;
            $display("FAIL all_busy_window: got %h want 03fe", busy_seen);
        end
    endtask

    task automatic test_mask_1010;
        preload(32'd15, 32'd103, 32'd34, 32'd123);
        run_op(4'b1010, 2'd3, 0, 0);
        n_tests++;
        if (result_at !== 34'd226 || mem[3] !== 32'd226) begin
            n_fail++;
            $display("FAIL m1010_result: result=%0d r3=%0d want 226 226", result_at, mem[3]);
        end
        n_tests++;
        if (ren_seen !== 16'h0088) begin
            n_fail++;
            $display("FAIL m1010_ren_pattern: got %h want 0088", ren_seen);
        end
        n_tests++;
        if (raddr_log[3] !== 2'd1 || raddr_log[7] !== 2'd3) begin
            n_fail++;
            $display("FAIL m1010_raddr: got %0d %0d want 1 3", raddr_log[3], raddr_log[7]);
        end
        n_tests++;
        if (mem[0] !== 32'd15 || mem[1] !== 32'd103 || mem[2] !== 32'd34) begin
            n_fail++;
            $display("FAIL m1010_others: got %0d %0d %0d want 15 103 34", mem[0], mem[1], mem[2]);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] exp_w;
`ifdef REGFILE_ACCUM_SAT_EN
        exp_w = 32'hFFFF_FFFF;
`else
        exp_w = 32'hFFFF_FFFC;
`endif
        preload(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(4'b1111, 2'd1, 0, 0);
        n_tests++;
        if (result_at !== 34'h3_FFFF_FFFC || ovf_at !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_result: got %h ovf=%b want 3fffffffc 1", result_at, ovf_at);
        end
        n_tests++;
        if (wdata_at !== exp_w || mem[1] !== exp_w) begin
            n_fail++;
            $display("FAIL ovf_wdata: wdata=%h r1=%h want %h", wdata_at, mem[1], exp_w);
        end
        n_tests++;
        if (result !== 34'h3_FFFF_FFFC || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: got %h ovf=%b want 3fffffffc 1", result, ovf);
        end
    endtask

    task automatic test_mask_zero;
        preload(32'd15, 32'd103, 32'd34, 32'd123);
        run_op(4'b0000, 2'd2, 0, 0);
        n_tests++;
        if (result_at !== 34'd0 || ovf_at !== 1'b0 || done_cyc !== 9) begin
            n_fail++;
            $display("FAIL zero_result: got %0d ovf=%b cyc=%0d want 0 0 9", result_at, ovf_at, done_cyc);
        end
        n_tests++;
        if (mem[2] !== 32'd0 || wen_cnt !== 1) begin
            n_fail++;
            $display("FAIL zero_writeback: r2=%0d wen_cnt=%0d want 0 1", mem[2], wen_cnt);
        end
        n_tests++;
        if (ren_seen !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_no_ren: got %h want 0000", ren_seen);
        end
    endtask

    task automatic test_start_while_busy;
        preload(32'd15, 32'd103, 32'd34, 32'd123);
        run_op(4'b1111, 2'd0, 4, 0);
        n_tests++;
        if (done_cnt !== 1 || done_cyc !== 9) begin
            n_fail++;
            $display("FAIL busy_start_done: cnt=%0d cyc=%0d want 1 9", done_cnt, done_cyc);
        end
        n_tests++;
        if (result !== 34'd275 || mem[0] !== 32'd275 || mem[1] !== 32'd103) begin
            n_fail++;
            $display("FAIL busy_start_result: result=%0d r0=%0d r1=%0d want 275 275 103",
                     result, mem[0], mem[1]);
        end
        n_tests++;
        if (busy_seen !== 16'h03FE) begin
            n_fail++;
            $display("FAIL busy_start_window: got %h want 03fe", busy_seen);
        end
    endtask

    task automatic test_reset_mid_op;
        preload(32'd15, 32'd103, 32'd34, 32'd123);
        run_op(4'b1111, 2'd0, 0, 6);
        n_tests++;
        if (rst_snap !== 75'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h want 0", rst_snap);
        end
        n_tests++;
        if (done_cnt !== 0 || wen_cnt !== 0 || mem[0] !== 32'd15) begin
            n_fail++;
            $display("FAIL midrst_no_write: done=%0d wen=%0d r0=%0d want 0 0 15",
                     done_cnt, wen_cnt, mem[0]);
        end
        run_op(4'b0110, 2'd0, 0, 0);
        n_tests++;
        if (done_cyc !== 9 || result_at !== 34'd137 || mem[0] !== 32'd137) begin
            n_fail++;
            $display("FAIL midrst_fresh: cyc=%0d result=%0d r0=%0d want 9 137 137",
                     done_cyc, result_at, mem[0]);
        end
    endtask

    initial begin
        test_reset();
        test_sum_all();
        test_mask_1010();
        test_overflow();
        test_mask_zero();
        test_start_while_busy();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
